// File: rtl/tb_uart_host_bfm.sv
// Host-side UART model: FIFO-fed transmitter with CTS flow control, receiver with
// framing check, and a registered CTS output toward the DUT.
module tb_uart_host_bfm #(
   parameter int CLK_DIV   = 288,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 16,
   parameter int HONOR_CTS = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       tx,
   input  logic       fpga_cts,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_error,
   input  logic       host_cts_en,
   output logic       ch552_cts,
   output logic       tx_busy,
   output logic [8:0] tx_level
);

   localparam int TW = $clog2(CLK_DIV) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [TW-1:0] BIT_END  = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] HALF_END = TW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * CLK_DIV - 1);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [8:0]    FULL_LVL = 9'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // TX FIFO
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, tx_load;

   assign in_ready = (tx_level != FULL_LVL);
   assign push     = in_valid && in_ready;
   assign pop      = tx_load;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tx_level <= tx_level + 9'd1;
            2'b01:   tx_level <= tx_level - 9'd1;
            default: tx_level <= tx_level;
         endcase
      end
   end

   // TX FSM
   state_t        tx_state, tx_next;
   logic [TW-1:0] tx_timer;
   logic [3:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_start_ok, tx_bit_end;

   assign tx_start_ok = (tx_level != 9'd0) && (fpga_cts || (HONOR_CTS == 0));
   assign tx_bit_end  = (tx_timer == BIT_END);
   assign tx_load     = (tx_state == S_IDLE) && tx_start_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tx_state <= S_IDLE;
      else          tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (tx_start_ok) tx_next = S_START;
         S_START: if (tx_bit_end) tx_next = S_DATA;
         S_DATA:  if (tx_bit_end && tx_bit == LAST_BIT) tx_next = S_STOP;
         S_STOP:  if (tx_timer == STOP_END) tx_next = S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx      = 1'b1;
      tx_busy = (tx_state != S_IDLE);
      case (tx_state)
         S_START: tx = 1'b0;
         S_DATA:  tx = tx_shift[0];
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_timer <= '0;
         tx_bit   <= '0;
      end else if (tx_next != tx_state || tx_state == S_IDLE) begin
         tx_timer <= '0;
         tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_bit_end) begin
         tx_timer <= '0;
         tx_bit   <= tx_bit + 4'd1;
      end else begin
         tx_timer <= tx_timer + T_ONE;
      end
   end

   // Bits above DATA_BITS-1 are loaded but never shifted out.
   always_ff @(posedge clk) begin
      if (tx_load)                              tx_shift <= fifo_mem[rd_ptr];
      else if (tx_state == S_DATA && tx_bit_end) tx_shift <= tx_shift >> 1;
   end

   // RX synchroniser and FSM
   logic [1:0]    rx_sync;
   logic          rx_s, rx_prev, rx_brk;
   state_t        rx_state, rx_next;
   logic [TW-1:0] rx_timer;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_bit_end, rx_data_smp, rx_stop_smp;

   assign rx_s       = rx_sync[1];
   assign rx_bit_end = (rx_timer == BIT_END);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
      end else begin
         rx_sync  <= {rx_sync[0], rx};
         rx_prev  <= rx_s;
         rx_state <= rx_next;
      end
   end

   // A low stop bit parks the FSM in STOP until the line returns high.
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_prev && !rx_s) rx_next = S_START;
         S_START: if (rx_timer == HALF_END) rx_next = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (rx_bit_end && rx_bit == LAST_BIT) rx_next = S_STOP;
         S_STOP: begin
            if (rx_brk) begin
               if (rx_s) rx_next = S_IDLE;
            end else if (rx_bit_end && rx_s) begin
               rx_next = S_IDLE;
            end
         end
         default: rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_data_smp = (rx_state == S_DATA) && rx_bit_end;
      rx_stop_smp = (rx_state == S_STOP) && !rx_brk && rx_bit_end;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_timer <= '0;
         rx_bit   <= '0;
      end else if (rx_next != rx_state || rx_state == S_IDLE || rx_brk) begin
         rx_timer <= '0;
         rx_bit   <= '0;
      end else if (rx_data_smp) begin
         rx_timer <= '0;
         rx_bit   <= rx_bit + 4'd1;
      end else begin
         rx_timer <= rx_timer + T_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_data_smp) rx_shift <= {rx_s, rx_shift[7:1]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_brk    <= 1'b0;
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
         rx_data   <= '0;
         ch552_cts <= 1'b0;
      end else begin
         rx_valid  <= rx_stop_smp && rx_s;
         rx_error  <= rx_stop_smp && !rx_s;
         ch552_cts <= host_cts_en;
         if (rx_stop_smp && rx_s) rx_data <= rx_shift >> (8 - DATA_BITS);
         if (rx_state == S_STOP && rx_next == S_IDLE) rx_brk <= 1'b0;
         else if (rx_stop_smp && !rx_s)              rx_brk <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tb_uart_host_bfm.sv
// Bench for tb_uart_host_bfm: waveform-level TX monitor and RX byte scoreboard.
module tb_tb_uart_host_bfm;

   localparam int CLK_DIV   = 4;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int DEPTH     = 4;
   localparam int HONOR_CTS = 1;
   localparam int FRAME_CYC = CLK_DIV * (1 + DATA_BITS + STOP_BITS);
   localparam logic [63:0] BUSY_MASK = (64'd1 << FRAME_CYC) - 64'd1;

   logic       clk = 1'b0;
   logic       reset_n, in_valid, in_ready, tx, fpga_cts, rx_line;
   logic       rx_valid, rx_error, host_cts_en, ch552_cts, tx_busy;
   logic [7:0] in_data, rx_data;
   logic [8:0] tx_level;
   logic       loop_en, rx_drv;

   assign rx_line = loop_en ? tx : rx_drv;

   tb_uart_host_bfm #(
      .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
      .DEPTH(DEPTH), .HONOR_CTS(HONOR_CTS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .tx(tx), .fpga_cts(fpga_cts), .rx(rx_line),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
      .host_cts_en(host_cts_en), .ch552_cts(ch552_cts), .tx_busy(tx_busy),
      .tx_level(tx_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   int frames_done = 0, rx_valid_cnt = 0, rx_err_cnt = 0;
   int push_cyc;
   bit mon_en;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   int start_q[$];

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_rx;
   } lb_vec_t;
   lb_vec_t lb_tab [3];
   logic [7:0] fifo_bytes [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Ideal line waveform, one sample per clock, for a frame carrying d.
   function automatic logic [63:0] frame_wave(input logic [7:0] d);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < FRAME_CYC; k++) begin
         if (k < CLK_DIV)                        w[k] = 1'b0;
         else if (k < CLK_DIV * (1 + DATA_BITS)) w[k] = d[(k - CLK_DIV) / CLK_DIV];
         else                                    w[k] = 1'b1;
      end
      return w;
   endfunction

   always begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
         logic [63:0] w, b;
         int st;
         st = cyc;
         w = '0;
         b = '0;
         w[0] = tx;
         b[0] = tx_busy;
         for (int k = 1; k < FRAME_CYC; k++) begin
            @(negedge clk);
            w[k] = tx;
            b[k] = tx_busy;
         end
         @(negedge clk);
         check("tx_idle_after", {62'd0, tx, tx_busy}, 64'h2);
         if (tx_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected: got frame 0x%0h, required none", w);
         end else begin
            check("tx_frame", w, frame_wave(tx_q.pop_front()));
            check("tx_busy_frame", b, BUSY_MASK);
         end
         start_q.push_back(st);
         frames_done++;
      end
   end

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_valid_cnt++;
         if (rx_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_unexpected: got 0x%0h, required no byte", rx_data);
         end else begin
            check("rx_byte", {56'd0, rx_data}, {56'd0, rx_q.pop_front()});
         end
      end
      if (rx_error === 1'b1) rx_err_cnt++;
   end

   // Called at a negedge; returns at the following negedge.
   task automatic push(input logic [7:0] d, input bit exp_acc);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_acc});
      if (exp_acc) tx_q.push_back(d);
      @(posedge clk);
      #1;
      push_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n, input string name);
      int t = 0;
      while (frames_done < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check(name, 64'(frames_done), 64'(n));
   endtask

   task automatic wait_rx(input int n, input string name);
      int t = 0;
      while (rx_valid_cnt < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(name, 64'(rx_valid_cnt), 64'(n));
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop_lvl);
      rx_drv = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < DATA_BITS; i++) begin
         rx_drv = d[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx_drv = stop_lvl;
      repeat (CLK_DIV) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lvl, f0, v0, e0, rel;
      lb_tab[0] = '{8'h00, 8'h00};
      lb_tab[1] = '{8'hFF, 8'hFF};
      lb_tab[2] = '{8'h5A, 8'h5A};
      fifo_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; fpga_cts = 1'b0;
      host_cts_en = 1'b1; loop_en = 1'b0; rx_drv = 1'b1; mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", {63'd0, tx}, 64'd1);
      check("rst_tx_busy", {63'd0, tx_busy}, 64'd0);
      check("rst_tx_level", {55'd0, tx_level}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_rx_flags", {62'd0, rx_valid, rx_error}, 64'd0);
      check("rst_rx_data", {56'd0, rx_data}, 64'd0);
      check("rst_ch552_cts", {63'd0, ch552_cts}, 64'd0);
      reset_n = 1'b1;
      host_cts_en = 1'b0;
      @(negedge clk);

      // Single byte, exact timing
      fpga_cts = 1'b1;
      push(8'hA5, 1'b1);
      check("single_level", {55'd0, tx_level}, 64'd1);
      check("single_tx_idle", {63'd0, tx}, 64'd1);
      wait_frames(1, "single_frame_done");
      check("single_start", 64'(start_q[$]), 64'(push_cyc + 1));

      // Flow control: held while CTS low, never truncated once started
      fpga_cts = 1'b0;
      push(8'h3C, 1'b1);
      repeat (10) @(negedge clk);
      check("cts_hold_tx", {62'd0, tx, tx_busy}, 64'h2);
      check("cts_hold_level", {55'd0, tx_level}, 64'd1);
      fpga_cts = 1'b1;
      rel = cyc;
      repeat (12) @(negedge clk);
      fpga_cts = 1'b0;
      wait_frames(2, "cts_frame_done");
      check("cts_start", 64'(start_q[$]), 64'(rel + 1));

      // FIFO full, then back-to-back drain in order
      lvl = 0;
      for (int i = 0; i < 5; i++) begin
         push(fifo_bytes[i], lvl < DEPTH);
         if (lvl < DEPTH) lvl++;
      end
      check("full_level", {55'd0, tx_level}, 64'(DEPTH));
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      start_q.delete();
      f0 = frames_done;
      fpga_cts = 1'b1;
      wait_frames(f0 + 4, "full_frames_done");
      for (int i = 1; i < 4; i++)
         check("b2b_gap", 64'(start_q[i] - start_q[i-1]), 64'(FRAME_CYC + 1));

      // Loopback, table driven; ch552_cts low must not gate reception
      loop_en = 1'b1;
      f0 = frames_done;
      v0 = rx_valid_cnt;
      e0 = rx_err_cnt;
      for (int i = 0; i < 3; i++) begin
         rx_q.push_back(lb_tab[i].exp_rx);
         push(lb_tab[i].din, 1'b1);
      end
      wait_frames(f0 + 3, "loop_frames_done");
      wait_rx(v0 + 3, "loop_rx_count");
      check("loop_no_error", 64'(rx_err_cnt), 64'(e0));
      check("loop_ch552_low", {63'd0, ch552_cts}, 64'd0);
      loop_en = 1'b0;
      rx_drv = 1'b1;
      repeat (4) @(negedge clk);

      // RX glitch, framing error, then recovery
      v0 = rx_valid_cnt;
      e0 = rx_err_cnt;
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_no_valid", 64'(rx_valid_cnt), 64'(v0));
      check("glitch_no_error", 64'(rx_err_cnt), 64'(e0));
      drive_frame(8'h96, 1'b0);
      repeat (8) @(negedge clk);
      rx_drv = 1'b1;
      repeat (10) @(negedge clk);
      check("ferr_error_once", 64'(rx_err_cnt), 64'(e0 + 1));
      check("ferr_no_valid", 64'(rx_valid_cnt), 64'(v0));
      check("ferr_data_kept", {56'd0, rx_data}, 64'h5A);
      rx_q.push_back(8'hC3);
      drive_frame(8'hC3, 1'b1);
      wait_rx(v0 + 1, "recover_rx_count");
      check("recover_no_error", 64'(rx_err_cnt), 64'(e0 + 1));

      // Reset in the middle of a frame
      mon_en = 1'b0;
      host_cts_en = 1'b1;
      fpga_cts = 1'b1;
      push(8'hE7, 1'b1);
      push(8'h18, 1'b1);
      tx_q.delete();
      repeat (10) @(negedge clk);
      check("pre_rst_busy", {63'd0, tx_busy}, 64'd1);
      check("pre_rst_level", {55'd0, tx_level}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx", {62'd0, tx, tx_busy}, 64'h2);
      check("mid_rst_level", {55'd0, tx_level}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_ch552", {63'd0, ch552_cts}, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_ch552_low", {63'd0, ch552_cts}, 64'd0);
      @(negedge clk);
      check("post_rst_ch552_high", {63'd0, ch552_cts}, 64'd1);
      mon_en = 1'b1;
      f0 = frames_done;
      push(8'h81, 1'b1);
      wait_frames(f0 + 1, "post_rst_frame_done");
      check("post_rst_start", 64'(start_q[$]), 64'(push_cyc + 1));
      check("tx_q_drained", 64'(tx_q.size()), 64'd0);
      check("rx_q_drained", 64'(rx_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tb_uart_host_bfm.md
Name: tb_uart_host_bfm

Overview:
- Parametrised host-side UART model that replaces the static idle drive of the DUT serial input in the application_fpga simulation bench.
- Serialises bytes queued by the bench onto interface_tx and honours the DUT's interface_fpga_cts flow control.
- Deserialises interface_rx into bytes with framing checks, and drives interface_ch552_cts under bench control.
- Written in synthesizable RTL so it can also be used as a loopback host in FPGA-level tests.

Parameters:
- CLK_DIV, 288, clock cycles per UART bit period; legal range 4..65535.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.
- STOP_BITS, 1, stop bits per transmitted frame; legal values 1 or 2.
- DEPTH, 16, TX FIFO depth in bytes; must be a power of two, 2..256.
- HONOR_CTS, 1, when 1 a frame starts only while fpga_cts is high; when 0 fpga_cts is ignored.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  bench offers a byte for transmission
- in_data  in  8  byte to transmit; bits above DATA_BITS-1 are ignored
- in_ready  out  1  TX FIFO not full
- tx  out  1  serial line to DUT interface_tx
- fpga_cts  in  1  DUT interface_fpga_cts (DUT can accept data)
- rx  in  1  serial line from DUT interface_rx
- rx_valid  out  1  one-cycle pulse: received byte on rx_data
- rx_data  out  8  received byte, zero-extended above DATA_BITS
- rx_error  out  1  one-cycle pulse: framing error (stop bit sampled low)
- host_cts_en  in  1  bench request to allow the DUT to send
- ch552_cts  out  1  to DUT interface_ch552_cts; host_cts_en registered by one flop
- tx_busy  out  1  TX FSM not in IDLE
- tx_level  out  9  current TX FIFO occupancy, 0..DEPTH

Behaviour:
- Reset values (async, while reset_n low):
  - tx=1, tx_busy=0, tx_level=0, in_ready=1
  - rx_valid=0, rx_error=0, rx_data=0, ch552_cts=0
  - FIFO pointers cleared; both FSMs in IDLE
- Reset asserted mid-frame aborts the frame immediately and forces tx high.
- TX FIFO:
  - Push when in_valid && in_ready at a rising edge.
  - Pop when the TX FSM loads a byte.
  - Push and pop in the same cycle leave tx_level unchanged.
  - in_ready = (tx_level != DEPTH), combinational from tx_level.
  - Pointers wrap modulo DEPTH; a full FIFO refuses writes, data is never overwritten.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when FIFO non-empty and (fpga_cts || !HONOR_CTS). The byte is popped on this edge and tx goes low.
  - A byte pushed into an empty FIFO at edge N with CTS high gives tx low after edge N+1.
  - START lasts CLK_DIV cycles, then DATA.
  - DATA: DATA_BITS bits, each exactly CLK_DIV cycles, LSB first.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames.
  - fpga_cts is checked only in IDLE. Deassertion mid-frame never truncates a frame.
  - fpga_cts is used directly (same clock domain in simulation).
- RX path:
  - rx passes through a 2-flop synchroniser (reset value 1).
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronised falling edge.
  - At CLK_DIV/2 cycles into START, rx is resampled: low → DATA; high → glitch, return to IDLE with no pulse.
  - DATA samples DATA_BITS bits at CLK_DIV intervals from mid-start.
  - STOP sample CLK_DIV later:
    - high → rx_valid pulses one cycle and rx_data updates on the same edge.
    - low → rx_error pulses one cycle, rx_data unchanged, FSM waits for rx high before returning to IDLE.
  - Only one stop bit is checked on receive regardless of STOP_BITS.
  - rx_data holds its value until the next valid byte.
  - The RX path has no backpressure; the bench must consume each pulse.
- ch552_cts follows host_cts_en with one cycle latency. It does not gate the RX FSM: bytes received while low are still reported.
- Counters: bit timer of width $clog2(CLK_DIV)+1 and bit counter of width 4; both reset to 0 at every state entry.

Test Plan (CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, DEPTH=4, HONOR_CTS=1 unless noted):
- Single byte: fpga_cts=1, push 0xA5 at edge N → tx low from N+1 for 4 cycles; bits 1,0,1,0,0,1,0,1 at 4 cycles each; high stop bit; tx_busy high for 40 cycles.
- Flow control: fpga_cts=0, push 0x3C → tx stays 1, tx_level=1. Raise fpga_cts → frame starts next edge. Drop fpga_cts mid-DATA → frame completes intact.
- FIFO full: hold fpga_cts=0, push 5 bytes → in_ready low after the 4th, 5th not accepted, tx_level=4. Release CTS → 4 frames back-to-back, 1 idle cycle apart, in original order.
- Loopback: tx tied to rx, push 0x00, 0xFF, 0x5A → three rx_valid pulses with those values, no rx_error.
- RX errors: drive a 2-cycle low glitch on rx → no pulse. Drive a frame with stop bit low → rx_error pulses once, rx_data retains the previous value.
- Reset mid-frame: assert reset_n low during DATA → tx=1, tx_level=0, in_ready=1 immediately. After release, a new 0x81 transmits correctly; ch552_cts=0 until host_cts_en is registered.
